// File: rtl/seg7_coord_scheduler.sv
// ---------------------------------------------------------------------------
// seg7_coord_scheduler
//
// Bus master that drives the 7-segment region peripheral on the shared 8-bit
// write bus. X is written to BASE_ADDR and Y to BASE_ADDR+1, always as an
// unsplit X-then-Y pair. Two requesters share the peripheral:
//   - slot0: mouse coordinate stream, latest value wins, no back-pressure.
//   - slot1: override source, valid/ready handshake, higher priority. After
//            an override pair, mouse pairs are held off for OVR_HOLD cycles.
// Every pair is followed by MIN_GAP idle cycles before the next may start.
//
// Handshake (override): a transfer happens on a rising CLK edge where
// O_VALID && O_READY. O_READY is registered and equals !pend1, so it drops
// the cycle after acceptance and rises the cycle after the slot is consumed.
//
// Ports:
//   CLK      in   1  system clock, all state on rising edge
//   RESET_N  in   1  asynchronous active-low reset
//   M_X/M_Y  in   8  mouse coordinate
//   M_VALID  in   1  mouse sample strobe (always accepted)
//   O_X/O_Y  in   8  override coordinate
//   O_VALID  in   1  override request
//   O_READY  out  1  override slot empty
//   BUS_GNT  in   1  write bus granted to this master
//   BUS_ADDR out  8  bus address (0 when BUS_WE=0)
//   BUS_DATA out  8  bus data (0 when BUS_WE=0)
//   BUS_WE   out  1  single-cycle write strobe
//   BUSY     out  1  FSM not in IDLE
//   COAL_CNT out  8  saturating count of overwritten, never-sent mouse samples
// ---------------------------------------------------------------------------
module seg7_coord_scheduler #(
    parameter logic [7:0]  BASE_ADDR = 8'hD0,
    parameter int unsigned MIN_GAP   = 16,
    parameter int unsigned OVR_HOLD  = 1000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] M_X,
    input  logic [7:0] M_Y,
    input  logic       M_VALID,
    input  logic [7:0] O_X,
    input  logic [7:0] O_Y,
    input  logic       O_VALID,
    output logic       O_READY,
    input  logic       BUS_GNT,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic       BUSY,
    output logic [7:0] COAL_CNT
);

    // Counter widths sized to hold the reload values.
    localparam int GW = (MIN_GAP  < 2) ? 1 : $clog2(MIN_GAP + 1);
    localparam int HW = (OVR_HOLD < 2) ? 1 : $clog2(OVR_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR_X = 2'd1,
        S_WR_Y = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_pend0;
    logic [7:0]      r_s0_x;
    logic [7:0]      r_s0_y;
    logic            r_pend1;
    logic [7:0]      r_s1_x;
    logic [7:0]      r_s1_y;

    logic [7:0]      r_wx;
    logic [7:0]      r_wy;
    logic            r_is_ovr;

    logic [GW-1:0]   r_gap;
    logic [HW-1:0]   r_hold;

    logic            r_bus_we;
    logic [7:0]      r_bus_addr;
    logic [7:0]      r_bus_data;
    logic            r_o_ready;
    logic            r_busy;
    logic [7:0]      r_coal;

    // ---------------------------------------------------------------------
    // Combinational next-state / next-output signals
    // ---------------------------------------------------------------------
    logic            w_sel_ovr;
    logic            w_sel_mouse;
    logic            w_we_nxt;
    logic [7:0]      w_addr_nxt;
    logic [7:0]      w_data_nxt;
    logic [GW-1:0]   w_gap_nxt;
    logic            w_hold_reload;
    logic [HW-1:0]   w_hold_nxt;
    logic            w_accept_ovr;
    logic            w_pend0_nxt;
    logic            w_pend1_nxt;
    logic            w_coal_inc;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state, slot selection and next bus outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_ovr     = 1'b0;
        w_sel_mouse   = 1'b0;
        w_we_nxt      = 1'b0;
        w_addr_nxt    = 8'h00;
        w_data_nxt    = 8'h00;
        w_gap_nxt     = r_gap;
        w_hold_reload = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Override wins regardless of the hold window; the mouse
                // is only eligible once the hold window has expired.
                if (r_pend1) begin
                    w_sel_ovr   = 1'b1;
                    w_state_nxt = S_WR_X;
                end else if (r_pend0 && (r_hold == '0)) begin
                    w_sel_mouse = 1'b1;
                    w_state_nxt = S_WR_X;
                end
            end

            S_WR_X: begin
                if (BUS_GNT) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = BASE_ADDR;
                    w_data_nxt  = r_wx;
                    w_state_nxt = S_WR_Y;
                end
            end

            S_WR_Y: begin
                // Without grant the pair simply pauses here; nothing else
                // can be selected until Y has gone out.
                if (BUS_GNT) begin
                    w_we_nxt      = 1'b1;
                    w_addr_nxt    = BASE_ADDR + 8'd1;
                    w_data_nxt    = r_wy;
                    w_gap_nxt     = GW'(MIN_GAP);
                    w_hold_reload = r_is_ovr;
                    w_state_nxt   = S_GAP;
                end
            end

            S_GAP: begin
                // Loaded with MIN_GAP, leave on the edge where it reads 1:
                // exactly MIN_GAP cycles are spent here.
                w_gap_nxt = r_gap - GW'(1);
                if (r_gap == GW'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Slot bookkeeping
    // ---------------------------------------------------------------------
    // Hold runs down every cycle regardless of state and floors at zero;
    // a completed override pair reloads it.
    always_comb begin
        w_hold_nxt = r_hold;
        if (w_hold_reload) begin
            w_hold_nxt = HW'(OVR_HOLD);
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - HW'(1);
        end
    end

    // A new mouse sample on the same edge the slot is consumed is not a
    // coalesce: the old sample is leaving for the working registers.
    assign w_coal_inc   = M_VALID && r_pend0 && !w_sel_mouse && (r_coal != 8'hFF);
    assign w_pend0_nxt  = M_VALID || (r_pend0 && !w_sel_mouse);

    // O_READY is low whenever pend1 is set, so acceptance and consumption
    // of slot1 can never coincide.
    assign w_accept_ovr = O_VALID && r_o_ready;
    assign w_pend1_nxt  = w_accept_ovr || (r_pend1 && !w_sel_ovr);

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pend0    <= 1'b0;
            r_s0_x     <= 8'h00;
            r_s0_y     <= 8'h00;
            r_pend1    <= 1'b0;
            r_s1_x     <= 8'h00;
            r_s1_y     <= 8'h00;
            r_wx       <= 8'h00;
            r_wy       <= 8'h00;
            r_is_ovr   <= 1'b0;
            r_gap      <= '0;
            r_hold     <= '0;
            r_bus_we   <= 1'b0;
            r_bus_addr <= 8'h00;
            r_bus_data <= 8'h00;
            r_o_ready  <= 1'b1;
            r_busy     <= 1'b0;
            r_coal     <= 8'h00;
        end else begin
            // Slot0 (mouse): latest value wins.
            r_pend0 <= w_pend0_nxt;
            if (M_VALID) begin
                r_s0_x <= M_X;
                r_s0_y <= M_Y;
            end
            if (w_coal_inc) begin
                r_coal <= r_coal + 8'd1;
            end

            // Slot1 (override): single-entry handshaked buffer.
            r_pend1 <= w_pend1_nxt;
            if (w_accept_ovr) begin
                r_s1_x <= O_X;
                r_s1_y <= O_Y;
            end
            r_o_ready <= !w_pend1_nxt;

            // Working registers capture the slot contents before the slot
            // is overwritten on the same edge.
            if (w_sel_ovr) begin
                r_wx     <= r_s1_x;
                r_wy     <= r_s1_y;
                r_is_ovr <= 1'b1;
            end else if (w_sel_mouse) begin
                r_wx     <= r_s0_x;
                r_wy     <= r_s0_y;
                r_is_ovr <= 1'b0;
            end

            r_gap  <= w_gap_nxt;
            r_hold <= w_hold_nxt;

            r_bus_we   <= w_we_nxt;
            r_bus_addr <= w_addr_nxt;
            r_bus_data <= w_data_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign O_READY  = r_o_ready;
    assign BUS_WE   = r_bus_we;
    assign BUS_ADDR = r_bus_addr;
    assign BUS_DATA = r_bus_data;
    assign BUSY     = r_busy;
    assign COAL_CNT = r_coal;

endmodule

// File: tb/tb_seg7_coord_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for seg7_coord_scheduler (MIN_GAP=4, OVR_HOLD=20).
// Inputs change just after the falling edge; outputs are compared on the
// falling edge against constants and against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_seg7_coord_scheduler;

    localparam logic [7:0] BASE = 8'hD0;
    localparam int         GAP  = 4;
    localparam int         HOLD = 20;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] M_X = 8'h00, M_Y = 8'h00, O_X = 8'h00, O_Y = 8'h00;
    logic       M_VALID = 1'b0, O_VALID = 1'b0, BUS_GNT = 1'b1;
    logic       O_READY, BUS_WE, BUSY;
    logic [7:0] BUS_ADDR, BUS_DATA, COAL_CNT;

    always #5 CLK = ~CLK;

    seg7_coord_scheduler #(
        .BASE_ADDR (BASE),
        .MIN_GAP   (GAP),
        .OVR_HOLD  (HOLD)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .M_X      (M_X),
        .M_Y      (M_Y),
        .M_VALID  (M_VALID),
        .O_X      (O_X),
        .O_Y      (O_Y),
        .O_VALID  (O_VALID),
        .O_READY  (O_READY),
        .BUS_GNT  (BUS_GNT),
        .BUS_ADDR (BUS_ADDR),
        .BUS_DATA (BUS_DATA),
        .BUS_WE   (BUS_WE),
        .BUSY     (BUSY),
        .COAL_CNT (COAL_CNT)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: pending samples, a queue of writes still owed for the
    // current pair, and plain cycle counters for the gap and hold windows.
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        pair_q[$];
    bit         mdl_mp = 0, mdl_op = 0, pair_ovr = 0;
    logic [7:0] mdl_mx = 0, mdl_my = 0, mdl_ox = 0, mdl_oy = 0;
    int         gap_left = 0, hold_left = 0;
    logic       e_we = 0, e_ready = 1, e_busy = 0;
    logic [7:0] e_addr = 0, e_data = 0, e_coal = 0;

    function automatic wr_t mk(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        return w;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pair_q.delete();
            mdl_mp = 0; mdl_op = 0; pair_ovr = 0;
            gap_left = 0; hold_left = 0;
            e_we = 0; e_addr = 0; e_data = 0; e_ready = 1; e_busy = 0; e_coal = 0;
        end else begin
            bit  take_m;
            int  hold_old;
            wr_t w;
            take_m   = 0;
            hold_old = hold_left;
            hold_left = (hold_left > 0) ? hold_left - 1 : 0;
            e_we = 0; e_addr = 0; e_data = 0;
            if (pair_q.size() > 0) begin
                if (BUS_GNT) begin
                    w = pair_q.pop_front();
                    e_we = 1; e_addr = w.a; e_data = w.d;
                    if (pair_q.size() == 0) begin
                        gap_left = GAP;
                        if (pair_ovr) hold_left = HOLD;
                    end
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (mdl_op) begin
                pair_q.push_back(mk(BASE, mdl_ox));
                pair_q.push_back(mk(BASE + 8'd1, mdl_oy));
                pair_ovr = 1;
                mdl_op = 0;
            end else if (mdl_mp && hold_old == 0) begin
                pair_q.push_back(mk(BASE, mdl_mx));
                pair_q.push_back(mk(BASE + 8'd1, mdl_my));
                pair_ovr = 0;
                take_m = 1;
            end
            if (M_VALID) begin
                if (mdl_mp && !take_m && e_coal != 8'hFF) e_coal = e_coal + 8'd1;
                mdl_mx = M_X; mdl_my = M_Y; mdl_mp = 1;
            end else if (take_m) begin
                mdl_mp = 0;
            end
            if (O_VALID && e_ready) begin
                mdl_ox = O_X; mdl_oy = O_Y; mdl_op = 1;
            end
            e_ready = !mdl_op;
            e_busy  = (pair_q.size() > 0) || (gap_left > 0);
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic tick();
        @(negedge CLK);
        check("model", {5'd0, BUS_WE, BUS_ADDR, BUS_DATA, O_READY, BUSY, COAL_CNT},
                       {5'd0, e_we, e_addr, e_data, e_ready, e_busy, e_coal});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_write(input string name, input int budget,
                              output logic [7:0] a, output logic [7:0] d);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!BUS_WE && n < budget);
        check({name, "_seen"}, {31'd0, BUS_WE}, 32'd1);
        a = BUS_ADDR;
        d = BUS_DATA;
    endtask

    task automatic mouse_pulse(input logic [7:0] x, input logic [7:0] y);
        M_X = x; M_Y = y; M_VALID = 1'b1;
        tick();
        M_VALID = 1'b0;
    endtask

    task automatic ovr_pulse(input logic [7:0] x, input logic [7:0] y);
        O_X = x; O_Y = y; O_VALID = 1'b1;
        tick();
        O_VALID = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Directed table
    // -----------------------------------------------------------------------
    typedef struct {
        logic [7:0] mx;
        logic [7:0] my;
        logic [7:0] a0;
        logic [7:0] d0;
        logic [7:0] a1;
        logic [7:0] d1;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : main
        logic [7:0] a, d, first_x;
        logic [7:0] wa[4];
        logic [7:0] wd[4];
        int         cnt;

        vecs[0] = '{8'd60,  8'd50,  8'hD0, 8'd60,  8'hD1, 8'd50};
        vecs[1] = '{8'h00,  8'h00,  8'hD0, 8'h00,  8'hD1, 8'h00};
        vecs[2] = '{8'hFF,  8'hFF,  8'hD0, 8'hFF,  8'hD1, 8'hFF};
        vecs[3] = '{8'hA5,  8'h5A,  8'hD0, 8'hA5,  8'hD1, 8'h5A};

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_we",    {31'd0, BUS_WE},   32'd0);
        check("rst_addr",  {24'd0, BUS_ADDR}, 32'd0);
        check("rst_data",  {24'd0, BUS_DATA}, 32'd0);
        check("rst_ready", {31'd0, O_READY},  32'd1);
        check("rst_busy",  {31'd0, BUSY},     32'd0);
        check("rst_coal",  {24'd0, COAL_CNT}, 32'd0);
        RESET_N = 1'b1;
        ticks(2);

        // Single mouse pairs with latency and gap length
        for (int v = 0; v < 4; v++) begin
            mouse_pulse(vecs[v].mx, vecs[v].my);           // edge0 sampled
            tick();                                        // edge1: IDLE->WR_X
            check("lat_no_we", {31'd0, BUS_WE}, 32'd0);
            check("lat_busy",  {31'd0, BUSY},   32'd1);
            tick();                                        // edge2: X
            check("x_write", {15'd0, BUS_WE, BUS_ADDR, BUS_DATA}, {15'd0, 1'b1, vecs[v].a0, vecs[v].d0});
            tick();                                        // edge3: Y
            check("y_write", {15'd0, BUS_WE, BUS_ADDR, BUS_DATA}, {15'd0, 1'b1, vecs[v].a1, vecs[v].d1});
            for (int g = 0; g < GAP - 1; g++) begin
                tick();
                check("gap_busy", {31'd0, BUSY}, 32'd1);
            end
            tick();
            check("gap_end_busy", {31'd0, BUSY}, 32'd0);
            check("coal_zero", {24'd0, COAL_CNT}, 32'd0);
            ticks(2);
        end

        // Coalescing during GAP: only the last sample goes out
        mouse_pulse(8'd1, 8'd2);
        wait_write("pre_x", 10, a, d);
        tick();
        M_Y = 8'd77; M_VALID = 1'b1;
        M_X = 8'd10; tick();
        M_X = 8'd20; tick();
        M_X = 8'd30; tick();
        M_VALID = 1'b0;
        wait_write("coal_x", 20, a, d);
        check("coal_x_val", {16'd0, a, d}, {16'd0, BASE, 8'd30});
        tick();
        check("coal_y_val", {15'd0, BUS_WE, BUS_ADDR, BUS_DATA}, {15'd0, 1'b1, BASE + 8'd1, 8'd77});
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (BUS_WE) cnt++;
        end
        check("coal_one_pair", cnt, 0);
        check("coal_cnt2", {24'd0, COAL_CNT}, 32'd2);

        // Saturation: grant withheld so every later sample is overwritten
        BUS_GNT = 1'b0;
        first_x = 8'h00;
        for (int i = 0; i < 300; i++) begin
            M_X = 8'($urandom_range(0, 255));
            M_Y = 8'($urandom_range(0, 255));
            if (i == 0) first_x = M_X;
            M_VALID = 1'b1;
            tick();
        end
        M_VALID = 1'b0;
        tick();
        check("coal_sat", {24'd0, COAL_CNT}, 32'd255);
        BUS_GNT = 1'b1;
        wait_write("sat_x", 10, a, d);
        check("sat_first_x", {24'd0, d}, {24'd0, first_x});
        ticks(40);

        // Override arriving while a mouse pair sits in WR_X
        BUS_GNT = 1'b0;
        mouse_pulse(8'd60, 8'd50);
        tick();
        check("ovr_ready_before", {31'd0, O_READY}, 32'd1);
        ovr_pulse(8'd5, 8'd90);
        check("ovr_ready_low", {31'd0, O_READY}, 32'd0);
        BUS_GNT = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_write("ovr_seq", 20, a, d);
            wa[k] = a;
            wd[k] = d;
            if (k == 1) check("ovr_ready_wait", {31'd0, O_READY}, 32'd0);
        end
        check("seq0", {16'd0, wa[0], wd[0]}, {16'd0, 8'hD0, 8'd60});
        check("seq1", {16'd0, wa[1], wd[1]}, {16'd0, 8'hD1, 8'd50});
        check("seq2", {16'd0, wa[2], wd[2]}, {16'd0, 8'hD0, 8'd5});
        check("seq3", {16'd0, wa[3], wd[3]}, {16'd0, 8'hD1, 8'd90});
        check("ovr_ready_back", {31'd0, O_READY}, 32'd1);
        ticks(40);

        // Hold window after an override pair
        ovr_pulse(8'd7, 8'd8);
        wait_write("hold_ovr_x", 10, a, d);
        tick();
        check("hold_ovr_y", {15'd0, BUS_WE, BUS_ADDR, BUS_DATA}, {15'd0, 1'b1, 8'hD1, 8'd8});
        mouse_pulse(8'd33, 8'd44);
        cnt = 1;
        while (!BUS_WE && cnt < 60) begin
            tick();
            cnt++;
        end
        check("hold_delay", cnt, HOLD + 2);
        check("hold_mouse_x", {15'd0, BUS_WE, BUS_ADDR, BUS_DATA}, {15'd0, 1'b1, 8'hD0, 8'd33});
        ticks(30);

        // Grant stall between X and Y
        mouse_pulse(8'h11, 8'h22);
        wait_write("stall_x", 10, a, d);
        check("stall_x_val", {16'd0, a, d}, {16'd0, 8'hD0, 8'h11});
        BUS_GNT = 1'b0;
        O_X = 8'h66; O_Y = 8'h77; O_VALID = 1'b1;
        M_X = 8'h99; M_Y = 8'h98; M_VALID = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            O_VALID = 1'b0;
            M_VALID = 1'b0;
            check("stall_bus", {7'd0, BUS_WE, BUS_ADDR, BUS_DATA}, 32'd0);
        end
        BUS_GNT = 1'b1;
        tick();
        check("stall_y", {15'd0, BUS_WE, BUS_ADDR, BUS_DATA}, {15'd0, 1'b1, 8'hD1, 8'h22});
        ticks(60);

        // Reset in the middle of a pair (held in WR_Y)
        mouse_pulse(8'hAB, 8'hCD);
        wait_write("rst_pair_x", 10, a, d);
        BUS_GNT = 1'b0;
        ovr_pulse(8'h01, 8'h02);
        check("mid_ready_low", {31'd0, O_READY}, 32'd0);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_bus", {7'd0, BUS_WE, BUS_ADDR, BUS_DATA}, 32'd0);
        check("mid_rst_ready", {31'd0, O_READY}, 32'd1);
        check("mid_rst_busy",  {31'd0, BUSY},    32'd0);
        check("mid_rst_coal",  {24'd0, COAL_CNT}, 32'd0);
        tick();
        RESET_N = 1'b1;
        BUS_GNT = 1'b1;
        tick();
        mouse_pulse(8'h12, 8'h34);
        wait_write("post_rst_x", 10, a, d);
        check("post_rst_x_val", {16'd0, a, d}, {16'd0, 8'hD0, 8'h12});
        tick();
        check("post_rst_y", {15'd0, BUS_WE, BUS_ADDR, BUS_DATA}, {15'd0, 1'b1, 8'hD1, 8'h34});
        ticks(10);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            M_VALID = ($urandom_range(0, 3) == 0);
            M_X     = 8'($urandom_range(0, 255));
            M_Y     = 8'($urandom_range(0, 255));
            O_VALID = ($urandom_range(0, 15) == 0);
            O_X     = 8'($urandom_range(0, 255));
            O_Y     = 8'($urandom_range(0, 255));
            BUS_GNT = ($urandom_range(0, 3) != 0);
            tick();
        end
        M_VALID = 1'b0;
        O_VALID = 1'b0;
        BUS_GNT = 1'b1;
        ticks(60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
